// File: rtl/bm_pkg.sv
// Shared block-matching pipeline constants, types and helpers.
package bm_pkg;
   localparam int BM_CW   = 16;
   localparam int BM_DW   = 8;
   localparam int BM_FW   = 8;
   localparam int BM_QW   = 10;
   localparam int BM_CNTW = 24;

   // Slice the low DW bits to get the invalid-disparity marker for any width.
   localparam logic [63:0] BM_DISP_INVALID = '1;

   function automatic int bm_uni_lat(input int qw);
      return qw + 2;
   endfunction

   typedef struct packed {
      logic             upd;
      logic [BM_CW-1:0] min1;
      logic [BM_CW-1:0] min2;
      logic [BM_DW-1:0] disp1;
      logic [BM_DW-1:0] disp2;
      logic [BM_FW-1:0] frac;
      logic             uni_on;
      logic [BM_QW-1:0] uni_thr;
   } bm_uni_sb_t;
endpackage

// File: rtl/bm_div_stage.sv
// One restoring-division step resolving quotient bit BIT; one enabled cycle per stage.
// cke=0 holds every register; there is no internal backpressure.
module bm_div_stage
   import bm_pkg::*;
#(
   parameter int  CW   = BM_CW,
   parameter int  QW   = BM_QW,
   parameter int  BIT  = QW - 1,
   parameter type SB_T = bm_uni_sb_t
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          cke,
   input  logic          v_i,
   input  logic          sat_i,
   input  logic [CW-1:0] rem_i,
   input  logic [CW-1:0] dvs_i,
   input  logic [QW-1:0] q_i,
   input  SB_T           sb_i,
   output logic          v_o,
   output logic          sat_o,
   output logic [CW-1:0] rem_o,
   output logic [QW-1:0] q_o,
   output SB_T           sb_o
);
   logic          v_q, v_d;
   logic          sat_q, sat_d;
   logic [CW-1:0] rem_q, rem_d;
   logic [QW-1:0] q_q, q_d;
   SB_T           sb_q, sb_d;
   logic [CW:0]   r2;
   logic          ge;

   // The remainder stays below the divisor, so doubling fits in CW+1 bits.
   always_comb begin
      r2    = {rem_i, 1'b0};
      ge    = (r2 >= {1'b0, dvs_i});
      v_d   = v_q;
      sat_d = sat_q;
      rem_d = rem_q;
      q_d   = q_q;
      sb_d  = sb_q;
      if (cke) begin
         v_d    = v_i;
         sat_d  = sat_i;
         sb_d   = sb_i;
         q_d    = q_i;
         q_d[BIT] = ge;
         rem_d  = ge ? CW'(r2 - {1'b0, dvs_i}) : r2[CW-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q   <= 1'b0;
         sat_q <= 1'b0;
         rem_q <= '0;
         q_q   <= '0;
         sb_q  <= '0;
      end else begin
         v_q   <= v_d;
         sat_q <= sat_d;
         rem_q <= rem_d;
         q_q   <= q_d;
         sb_q  <= sb_d;
      end
   end

   assign v_o   = v_q;
   assign sat_o = sat_q;
   assign rem_o = rem_q;
   assign q_o   = q_q;
   assign sb_o  = sb_q;
endmodule

// File: rtl/bm_uni_filter.sv
// Uniqueness filter: ratio = min1/min2 in Q0.QW, threshold, masked disparity, per-frame reject count.
// Latency QW+2 enabled cycles, one pixel per cycle; cke=0 freezes all stages, no internal backpressure.
module bm_uni_filter
   import bm_pkg::*;
#(
   parameter int CW   = BM_CW,
   parameter int DW   = BM_DW,
   parameter int FW   = BM_FW,
   parameter int QW   = BM_QW,
   parameter int CNTW = BM_CNTW
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            cke,
   input  logic            uni_on,
   input  logic [QW-1:0]   uni_thr,
   input  logic            frame_start,
   input  logic            vin,
   input  logic            upd_in,
   input  logic [CW-1:0]   min1_in,
   input  logic [CW-1:0]   min2_in,
   input  logic [DW-1:0]   disp1_in,
   input  logic [DW-1:0]   disp2_in,
   input  logic [FW-1:0]   frac_in,
   output logic            vout,
   output logic            upd_out,
   output logic [CW-1:0]   min1_out,
   output logic [CW-1:0]   min2_out,
   output logic [DW-1:0]   disp1_out,
   output logic [DW-1:0]   disp2_out,
   output logic [FW-1:0]   frac_out,
   output logic [QW-1:0]   uni_ratio,
   output logic            uni_pass,
   output logic [DW-1:0]   disp_sel,
   output logic [CNTW-1:0] rej_cnt
);
   typedef struct packed {
      logic          upd;
      logic [CW-1:0] min1;
      logic [CW-1:0] min2;
      logic [DW-1:0] disp1;
      logic [DW-1:0] disp2;
      logic [FW-1:0] frac;
      logic          uni_on;
      logic [QW-1:0] uni_thr;
   } sb_t;

   logic v0_q, v0_d;
   logic sat0_q, sat0_d;
   sb_t  sb0_q, sb0_d;

   always_comb begin
      v0_d   = v0_q;
      sat0_d = sat0_q;
      sb0_d  = sb0_q;
      if (cke) begin
         v0_d          = vin;
         sat0_d        = (min2_in == '0) || (min1_in >= min2_in);
         sb0_d.upd     = upd_in;
         sb0_d.min1    = min1_in;
         sb0_d.min2    = min2_in;
         sb0_d.disp1   = disp1_in;
         sb0_d.disp2   = disp2_in;
         sb0_d.frac    = frac_in;
         sb0_d.uni_on  = uni_on;
         sb0_d.uni_thr = uni_thr;
      end
   end

   logic          v_s   [QW+1];
   logic          sat_s [QW+1];
   logic [CW-1:0] rem_s [QW+1];
   logic [QW-1:0] q_s   [QW+1];
   sb_t           sb_s  [QW+1];

   assign v_s[0]   = v0_q;
   assign sat_s[0] = sat0_q;
   assign rem_s[0] = sb0_q.min1;
   assign q_s[0]   = '0;
   assign sb_s[0]  = sb0_q;

   for (genvar i = 0; i < QW; i++) begin : g_div
      bm_div_stage #(
         .CW   (CW),
         .QW   (QW),
         .BIT  (QW - 1 - i),
         .SB_T (sb_t)
      ) u_stage (
         .clk   (clk),
         .rst   (rst),
         .cke   (cke),
         .v_i   (v_s[i]),
         .sat_i (sat_s[i]),
         .rem_i (rem_s[i]),
         .dvs_i (sb_s[i].min2),
         .q_i   (q_s[i]),
         .sb_i  (sb_s[i]),
         .v_o   (v_s[i+1]),
         .sat_o (sat_s[i+1]),
         .rem_o (rem_s[i+1]),
         .q_o   (q_s[i+1]),
         .sb_o  (sb_s[i+1])
      );
   end

   logic [QW-1:0]   ratio_f;
   logic            pass_f;
   logic            rej_ret;
   logic            vout_q, vout_d;
   logic            upd_q, upd_d;
   logic [CW-1:0]   min1_q, min1_d, min2_q, min2_d;
   logic [DW-1:0]   disp1_q, disp1_d, disp2_q, disp2_d, dsel_q, dsel_d;
   logic [FW-1:0]   frac_q, frac_d;
   logic [QW-1:0]   ratio_q, ratio_d;
   logic            pass_q, pass_d;
   logic [CNTW-1:0] rej_cnt_q, rej_cnt_d;

   always_comb begin
      ratio_f = sat_s[QW] ? '1 : q_s[QW];
      pass_f  = 1'b1;
      if (sb_s[QW].uni_on) pass_f = (ratio_f <= sb_s[QW].uni_thr);
      else                 ratio_f = '0;
   end

   // Outputs only reload on a valid pixel so they hold through bubbles.
   always_comb begin
      vout_d    = vout_q;
      upd_d     = upd_q;
      min1_d    = min1_q;
      min2_d    = min2_q;
      disp1_d   = disp1_q;
      disp2_d   = disp2_q;
      frac_d    = frac_q;
      ratio_d   = ratio_q;
      pass_d    = pass_q;
      dsel_d    = dsel_q;
      rej_cnt_d = rej_cnt_q;
      rej_ret   = cke && v_s[QW] && !pass_f;
      if (cke) begin
         vout_d = v_s[QW];
         if (v_s[QW]) begin
            upd_d   = sb_s[QW].upd;
            min1_d  = sb_s[QW].min1;
            min2_d  = sb_s[QW].min2;
            disp1_d = sb_s[QW].disp1;
            disp2_d = sb_s[QW].disp2;
            frac_d  = sb_s[QW].frac;
            ratio_d = ratio_f;
            pass_d  = pass_f;
            dsel_d  = pass_f ? sb_s[QW].disp1 : BM_DISP_INVALID[DW-1:0];
         end
      end
      if (rej_ret && (rej_cnt_q != '1)) rej_cnt_d = rej_cnt_q + CNTW'(1);
      if (frame_start) rej_cnt_d = rej_ret ? CNTW'(1) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v0_q      <= 1'b0;
         sat0_q    <= 1'b0;
         sb0_q     <= '0;
         vout_q    <= 1'b0;
         upd_q     <= 1'b0;
         min1_q    <= '0;
         min2_q    <= '0;
         disp1_q   <= '0;
         disp2_q   <= '0;
         frac_q    <= '0;
         ratio_q   <= '0;
         pass_q    <= 1'b0;
         dsel_q    <= '0;
         rej_cnt_q <= '0;
      end else begin
         v0_q      <= v0_d;
         sat0_q    <= sat0_d;
         sb0_q     <= sb0_d;
         vout_q    <= vout_d;
         upd_q     <= upd_d;
         min1_q    <= min1_d;
         min2_q    <= min2_d;
         disp1_q   <= disp1_d;
         disp2_q   <= disp2_d;
         frac_q    <= frac_d;
         ratio_q   <= ratio_d;
         pass_q    <= pass_d;
         dsel_q    <= dsel_d;
         rej_cnt_q <= rej_cnt_d;
      end
   end

   assign vout      = vout_q;
   assign upd_out   = upd_q;
   assign min1_out  = min1_q;
   assign min2_out  = min2_q;
   assign disp1_out = disp1_q;
   assign disp2_out = disp2_q;
   assign frac_out  = frac_q;
   assign uni_ratio = ratio_q;
   assign uni_pass  = pass_q;
   assign disp_sel  = dsel_q;
   assign rej_cnt   = rej_cnt_q;
endmodule
